// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide unit:
//   - alucontrol encodings recognised by the unit (plus one ordinary ALU op)
//   - FSM state encoding
//   - a magnitude helper used for signed operand conditioning
// Optional feature macro used by the unit: MULDIV_FAST_MUL_EN
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    localparam int XLEN = 32;

    // Decoded EX-stage op codes (5-bit alucontrol).
    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_MULT  = 5'b10000;
    localparam logic [4:0] ALU_MULTU = 5'b10001;
    localparam logic [4:0] ALU_DIV   = 5'b10010;
    localparam logic [4:0] ALU_DIVU  = 5'b10011;
    localparam logic [4:0] ALU_MTHI  = 5'b10100;
    localparam logic [4:0] ALU_MTLO  = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Absolute value of a two's-complement operand when is_signed is set.
    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// Pipeline-side bundle of the multiply/divide unit.
//   start       EX-stage instruction valid for this unit
//   alucontrol  decoded op code
//   srca/srcb   rs / rt operands
//   flush       exception kill of the in-flight op
//   stall_o     pipeline hold request
//   ready_o     result commit cycle
//   hi_o/lo_o   registered HI / LO
// master = pipeline side, slave = muldiv_ctrl.
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start, alucontrol, srca, srcb, flush,
        input  stall_o, ready_o, hi_o, lo_o
    );

    modport slave (
        input  start, alucontrol, srca, srcb, flush,
        output stall_o, ready_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Restoring radix-2 unsigned divider datapath: one quotient bit per enabled
// cycle, 32 steps for a full result. Sequencing lives in the parent.
//   clk        clock
//   load       capture dividend/divisor, clear the partial remainder
//   en         perform one iteration
//   dividend   unsigned dividend (magnitude)
//   divisor    unsigned divisor (magnitude)
//   quotient   quotient shift register
//   remainder  partial remainder register
// -----------------------------------------------------------------------------
module div_iter (
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic [32:0] shifted;
    logic [32:0] trial;

    // Shift the next dividend bit into the remainder and try a subtraction.
    // Since rem < divisor, shifted < 2*divisor, so trial[32] is exactly the borrow.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvsr_q};
    end

    // NOTE: pure datapath registers carry no reset; load always precedes use.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
        end else if (en) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// HI/LO multiply/divide unit for the EX stage. Handles MULT, MULTU, DIV, DIVU,
// MTHI, MTLO; any other alucontrol with start is ignored.
//   clk   clock
//   rst   synchronous active-high reset
//   bus   muldiv_ctrl_if.slave: start, alucontrol, srca, srcb, flush in;
//         stall_o, ready_o, hi_o, lo_o out
// Multi-cycle ops stall for the accept cycle plus 32 iteration cycles, then
// spend one DONE cycle (ready_o=1) doing the sign fix and HI/LO commit.
// Macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU complete in one cycle
// with a combinational 64-bit product; otherwise they iterate like DIV.
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] hi_q, lo_q;

    // Op context captured when a multi-cycle op is accepted.
    logic        neg_q;          // quotient / product gets negated
    logic        neg_r;          // remainder takes the dividend's (negative) sign
    logic        div_zero;
    logic [31:0] dividend_raw;   // original srca, committed to HI on divide by zero

    logic        is_mul, is_div, is_signed, long_op, go;
    logic [31:0] mag_a, mag_b;
    logic [31:0] quo, rem;
    logic [31:0] res_hi, res_lo;
    logic        stall, ready;

    // ---------------------------------------------------------------- decode
    always_comb begin
        is_mul    = (bus.alucontrol == ALU_MULT) || (bus.alucontrol == ALU_MULTU);
        is_div    = (bus.alucontrol == ALU_DIV)  || (bus.alucontrol == ALU_DIVU);
        is_signed = (bus.alucontrol == ALU_MULT) || (bus.alucontrol == ALU_DIV);
`ifdef MULDIV_FAST_MUL_EN
        long_op   = is_div;
`else
        long_op   = is_div || is_mul;
`endif
        // An instruction is only taken from IDLE; DONE still sees the same one.
        go        = (state == IDLE) && bus.start && !bus.flush;
        mag_a     = magnitude(bus.srca, is_signed);
        mag_b     = magnitude(bus.srcb, is_signed);
    end

    // ------------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // Counter runs only while iterating; wrap 31->0 coincides with exit.
            if (state == MUL || state == DIV) cnt <= cnt + 5'd1;
            else                              cnt <= '0;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (go && long_op) begin
                    stall     = 1'b1;
                    state_nxt = is_div ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                stall = 1'b1;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush kills whatever is in flight; reset dominates everything.
        if (bus.flush) begin
            state_nxt = IDLE;
            stall     = 1'b0;
            ready     = 1'b0;
        end
        if (rst) begin
            stall = 1'b0;
            ready = 1'b0;
        end
    end

    // ------------------------------------------------------------ op context
    always_ff @(posedge clk) begin
        if (go && long_op) begin
            neg_q        <= is_signed && (bus.srca[31] ^ bus.srcb[31]);
            neg_r        <= is_signed && bus.srca[31];
            div_zero     <= (bus.srcb == 32'd0);
            dividend_raw <= bus.srca;
        end
    end

    // -------------------------------------------------------- divide datapath
    div_iter u_div_iter (
        .clk       (clk),
        .load      (go && is_div),
        .en        (state == DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem)
    );

    // ------------------------------------------------------ multiply datapath
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;

    // Low 64 bits of the product of sign/zero-extended operands are exact
    // for both signed and unsigned forms.
    always_comb begin
        ext_a     = is_signed ? {{32{bus.srca[31]}}, bus.srca} : {32'd0, bus.srca};
        ext_b     = is_signed ? {{32{bus.srcb[31]}}, bus.srcb} : {32'd0, bus.srcb};
        fast_prod = ext_a * ext_b;
    end
`else
    logic        op_div;
    logic [63:0] prod_q;
    logic [31:0] mcand_q;
    logic [32:0] mul_sum;

    // Shift-add: multiplier sits in prod_q[31:0] and is consumed LSB first
    // while partial sums enter from the top.
    always_comb begin
        mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    end

    always_ff @(posedge clk) begin
        if (go && long_op) op_div <= is_div;
        if (go && is_mul) begin
            prod_q  <= {32'd0, mag_b};
            mcand_q <= mag_a;
        end else if (state == MUL) begin
            prod_q  <= {mul_sum, prod_q[31:1]};
        end
    end
`endif

    // ------------------------------------------------------ DONE sign fix-up
    always_comb begin
        res_hi = neg_r ? -rem : rem;
        res_lo = neg_q ? -quo : quo;
        if (div_zero) begin
            res_hi = dividend_raw;
            res_lo = 32'hFFFF_FFFF;
        end
`ifndef MULDIV_FAST_MUL_EN
        if (!op_div) {res_hi, res_lo} = neg_q ? -prod_q : prod_q;
`endif
    end

    // ----------------------------------------------------------------- HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (go) begin
            if (bus.alucontrol == ALU_MTHI) hi_q <= bus.srca;
            if (bus.alucontrol == ALU_MTLO) lo_q <= bus.srca;
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul) {hi_q, lo_q} <= fast_prod;
`endif
        end else if (state == DONE && !bus.flush) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end
    end

    assign bus.stall_o = stall;
    assign bus.ready_o = ready;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl. Each op pushes its expected HI/LO and stall
// count onto a scoreboard queue; the entry is popped and compared when the
// DUT commits. A shadow HI/LO pair tracks values that must be preserved.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_STALLS = 33;
`endif
    localparam int DIV_STALLS = 33;
    localparam int BUDGET     = 100;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction (start held until commit) and check the result.
    task automatic run_op(input string tag, input logic [4:0] code,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int estalls);
        exp_t e;
        int   stalls;
        bit   got;
        sb.push_back('{tag, ehi, elo, estalls});
        bus.start      = 1'b1;
        bus.alucontrol = code;
        bus.srca       = a;
        bus.srcb       = b;
        if (estalls == 0) begin
            @(negedge clk);
            check({tag, " stall"}, 64'(bus.stall_o), 64'd0);
            check({tag, " ready"}, 64'(bus.ready_o), 64'd0);
            tick();
        end else begin
            stalls = 0;
            got    = 1'b0;
            for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (bus.ready_o) begin
                    got = 1'b1;
                    break;
                end
                if (bus.stall_o) stalls++;
                tick();
            end
            check({tag, " ready seen"}, 64'(got), 64'd1);
            check({tag, " stall cycles"}, 64'(stalls), 64'(estalls));
            check({tag, " stall in done"}, 64'(bus.stall_o), 64'd0);
            tick();
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        check({e.tag, " hi"}, 64'(bus.hi_o), 64'(e.hi));
        check({e.tag, " lo"}, 64'(bus.lo_o), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
        @(negedge clk);
        check({tag, " ready after"}, 64'(bus.ready_o), 64'd0);
        check({tag, " stall after"}, 64'(bus.stall_o), 64'd0);
        tick();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.alucontrol = ALU_ADD;
        bus.srca       = '0;
        bus.srcb       = '0;
        bus.flush      = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset hi",    64'(bus.hi_o),    64'd0);
        check("reset lo",    64'(bus.lo_o),    64'd0);
        check("reset stall", 64'(bus.stall_o), 64'd0);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        tick();

        // Divide
        run_op("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALLS);
        run_op("div -7/2",   ALU_DIV,  32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALLS);
        run_op("div -100/7", ALU_DIV,  32'hFFFF_FF9C, 32'd7,
               32'hFFFF_FFFE, 32'hFFFF_FFF2, DIV_STALLS);
        run_op("div 100/-7", ALU_DIV,  32'd100, 32'hFFFF_FFF9,
               32'd2, 32'hFFFF_FFF2, DIV_STALLS);
        run_op("divu 5/0",   ALU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_STALLS);
        run_op("div -16/0",  ALU_DIV,  32'hFFFF_FFF0, 32'd0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_STALLS);

        // Multiply
        run_op("mult -1*2",  ALU_MULT,  32'hFFFF_FFFF, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALLS);
        run_op("multu",      ALU_MULTU, 32'hFFFF_FFFF, 32'd2,
               32'd1, 32'hFFFF_FFFE, MUL_STALLS);
        run_op("mult min*min", ALU_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'd0, MUL_STALLS);

        // Unrelated op with start: nothing happens
        run_op("ignored add", ALU_ADD, 32'hDEAD_BEEF, 32'd1, m_hi, m_lo, 0);

        // Flush on the 10th DIV cycle
        bus.start      = 1'b1;
        bus.alucontrol = ALU_DIVU;
        bus.srca       = 32'd1000;
        bus.srcb       = 32'd3;
        tick();                      // now in DIV cycle 1
        repeat (9) tick();           // DIV cycle 10
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush stall", 64'(bus.stall_o), 64'd0);
        check("flush ready", 64'(bus.ready_o), 64'd0);
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush hi kept", 64'(bus.hi_o), 64'(m_hi));
        check("flush lo kept", 64'(bus.lo_o), 64'(m_lo));
        @(negedge clk);
        check("post flush stall", 64'(bus.stall_o), 64'd0);
        tick();
        // A full-length op right after shows the unit restarted from IDLE.
        run_op("divu 9/3 after flush", ALU_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, DIV_STALLS);

        // Reset mid-DIV
        bus.start      = 1'b1;
        bus.alucontrol = ALU_DIV;
        bus.srca       = 32'd77;
        bus.srcb       = 32'd5;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst hi", 64'(bus.hi_o), 64'd0);
        check("rst lo", 64'(bus.lo_o), 64'd0);
        @(negedge clk);
        check("rst stall", 64'(bus.stall_o), 64'd0);
        check("rst ready", 64'(bus.ready_o), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick();

        // MTHI immediately followed by MTLO
        sb.push_back('{"mthi", 32'h1234_5678, 32'd0, 0});
        bus.start      = 1'b1;
        bus.alucontrol = ALU_MTHI;
        bus.srca       = 32'h1234_5678;
        @(negedge clk);
        check("mthi stall", 64'(bus.stall_o), 64'd0);
        tick();
        bus.alucontrol = ALU_MTLO;
        bus.srca       = 32'h9ABC_DEF0;
        begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, " hi"}, 64'(bus.hi_o), 64'(e.hi));
            check({e.tag, " lo"}, 64'(bus.lo_o), 64'(e.lo));
        end
        sb.push_back('{"mtlo", 32'h1234_5678, 32'h9ABC_DEF0, 0});
        @(negedge clk);
        check("mtlo stall", 64'(bus.stall_o), 64'd0);
        tick();
        bus.start = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, " hi"}, 64'(bus.hi_o), 64'(e.hi));
            check({e.tag, " lo"}, 64'(bus.lo_o), 64'(e.lo));
        end
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset. Clock: clk. Reset: rst, synchronous, active-high.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- start  in  1  EX-stage instruction valid for this unit.
- alucontrol  in  5  decoded op code; encodings come from the shared defines header.
- srca  in  32  rs operand / dividend / multiplicand.
- srcb  in  32  rt operand / divisor / multiplier.
- flush  in  1  exception kill of the in-flight op.
- stall_o  out  1  pipeline hold request.
- ready_o  out  1  result commit cycle.
- hi_o  out  32  registered HI.
- lo_o  out  32  registered LO.

Function
REQ-003 SHALL react only to MULT, MULTU, DIV, DIVU, MTHI and MTLO; start with any other alucontrol SHALL be ignored.
REQ-004 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-005 SHALL, in IDLE with start and DIV/DIVU: latch operand magnitudes and sign flags, clear the 5-bit iteration counter, and go to DIV.
REQ-006 SHALL perform one restoring radix-2 iteration per DIV cycle; after count 31 it SHALL go to DONE. Counter wrap 31->0 is the exit condition.
REQ-007 SHALL, in DONE for signed ops, negate the quotient when operand signs differ and give the remainder the dividend's sign.
REQ-008 SHALL write LO=quotient and HI=remainder at the DONE clock edge, then return to IDLE.
REQ-009 SHALL, on divide by zero, commit LO=0xFFFFFFFF and HI=srca (latched) for both signedness modes, with normal latency.
REQ-010 SHALL drive stall_o=1 in the IDLE start cycle of a multi-cycle op and in every MUL/DIV cycle. stall_o SHALL be 0 in DONE and IDLE otherwise.
REQ-011 SHALL drive ready_o=1 only in DONE.
REQ-012 SHALL ignore start while in DONE, because the same instruction is still presented.
REQ-013 SHALL, for MTHI/MTLO in IDLE with start, write srca to HI/LO at the next edge, with stall_o=0 and no state change.
REQ-014 SHALL keep hi_o/lo_o as direct register outputs; MFHI/MFLO read them unchanged.
REQ-015 SHALL, on flush in any state, go to IDLE at the next edge with HI/LO unchanged and stall_o=0 in the flush cycle. flush SHALL override start.

Reset
REQ-016 SHALL, on rst=1 at a clock edge: state=IDLE, counter=0, hi_o=0, lo_o=0, stall_o=0, ready_o=0.
REQ-017 SHALL give rst priority over flush and start, and SHALL abandon any in-flight op without a HI/LO update.

Configuration
REQ-018 SHALL honour macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU in IDLE with start SHALL write the full 64-bit product to HI:LO at the next edge, with stall_o=0 and no MUL state.
- Undefined: MULT/MULTU SHALL go to MUL and run 32 shift-add iterations on magnitudes, then use DONE for sign fix and commit, with the same stall/ready timing as DIV.

Structure
REQ-019 SHALL take alucontrol encodings and FSM state constants from the shared defines header; there SHALL be no local literal op codes.
REQ-020 SHALL place the iterative divide datapath in one sub-module, div_iter, which holds the remainder/quotient shift registers, one step per enable. The FSM, counter, sign handling and HI/LO SHALL stay in muldiv_ctrl.

Verification
REQ-021 SHALL cover these directed scenarios:
- DIVU srca=100, srcb=7 -> LO=14, HI=2; stall_o high exactly 33 cycles; ready_o one cycle; values visible the cycle after DONE.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU srca=5, srcb=0 -> LO=0xFFFFFFFF, HI=5.
- MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=1, LO=0xFFFFFFFE. Run both with and without MULDIV_FAST_MUL_EN: 0 vs 33 stall cycles.
- Flush on the 10th DIV cycle -> IDLE next cycle, HI/LO keep prior values, stall_o low.
- rst mid-DIV -> all outputs zero next cycle. Then MTHI 0x12345678 followed immediately by MTLO 0x9ABCDEF0 -> both written, no stall.
